// File: rtl/dmem_ctrl.sv
// Data-memory access controller: splits one 8-thread warp request into four
// 2-lane memory beats, gathers load data and reports completion.
module dmem_ctrl #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                req_valid,
    output logic                                req_ready,
    input  logic [1:0]                          req_warp,
    input  logic [3:0]                          req_dest_reg,
    input  logic                                req_is_store,
    input  logic [7:0][ADDR_WIDTH-1:0]          req_addr,
    input  logic [7:0][DATA_WIDTH-1:0]          req_wdata,
    output logic                                mem_en,
    output logic                                mem_we,
    output logic [1:0][ADDR_WIDTH-1:0]          mem_addr,
    output logic [1:0][DATA_WIDTH-1:0]          mem_wdata,
    input  logic                                mem_gnt,
    input  logic                                mem_rvalid,
    input  logic [1:0][DATA_WIDTH-1:0]          mem_rdata,
    output logic                                wb_valid,
    output logic [1:0]                          wb_warp,
    output logic [3:0]                          wb_reg,
    output logic [7:0][DATA_WIDTH-1:0]          wb_data,
    output logic                                done_valid,
    output logic [1:0]                          done_warp
);

    localparam int unsigned CNT_W = 2;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t                        state;
    logic [CNT_W-1:0]              issue_cnt;
    logic [CNT_W-1:0]              rsp_cnt;
    logic [CNT_W-1:0]              issue_nxt;
    logic [1:0]                    warp_q;
    logic [3:0]                    dest_q;
    logic                          store_q;
    logic [7:0][ADDR_WIDTH-1:0]    addr_q;
    logic [7:0][DATA_WIDTH-1:0]    wdata_q;
    logic                          rsp_take;

    assign issue_nxt = issue_cnt + CNT_W'(1);
    // Responses are only meaningful for a load that is still collecting beats.
    assign rsp_take  = mem_rvalid && !store_q && (state == ISSUE || state == WAIT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            req_ready  <= 1'b0;
            issue_cnt  <= '0;
            rsp_cnt    <= '0;
            warp_q     <= '0;
            dest_q     <= '0;
            store_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            wb_valid   <= 1'b0;
            wb_warp    <= '0;
            wb_reg     <= '0;
            wb_data    <= '0;
            done_valid <= 1'b0;
            done_warp  <= '0;
        end else begin
            wb_valid   <= 1'b0;
            done_valid <= 1'b0;

            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_ready && req_valid) begin
                        req_ready    <= 1'b0;
                        warp_q       <= req_warp;
                        dest_q       <= req_dest_reg;
                        store_q      <= req_is_store;
                        addr_q       <= req_addr;
                        wdata_q      <= req_wdata;
                        issue_cnt    <= '0;
                        rsp_cnt      <= '0;
                        mem_en       <= 1'b1;
                        mem_we       <= req_is_store;
                        mem_addr[0]  <= req_addr[0];
                        mem_addr[1]  <= req_addr[1];
                        mem_wdata[0] <= req_wdata[0];
                        mem_wdata[1] <= req_wdata[1];
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Beat outputs advance only on grant; otherwise they hold.
                    if (mem_gnt) begin
                        issue_cnt <= issue_nxt;
                        if (issue_cnt == CNT_W'(3)) begin
                            mem_en <= 1'b0;
                            mem_we <= 1'b0;
                            if (store_q) begin
                                state      <= DONE;
                                done_valid <= 1'b1;
                                done_warp  <= warp_q;
                            end else begin
                                state <= WAIT;
                            end
                        end else begin
                            mem_addr[0]  <= addr_q[{issue_nxt, 1'b0}];
                            mem_addr[1]  <= addr_q[{issue_nxt, 1'b1}];
                            mem_wdata[0] <= wdata_q[{issue_nxt, 1'b0}];
                            mem_wdata[1] <= wdata_q[{issue_nxt, 1'b1}];
                        end
                    end
                end
                WAIT: begin
                end
                DONE: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase

            // Gather path runs independently of the issue counter.
            if (rsp_take) begin
                wb_data[{rsp_cnt, 1'b0}] <= mem_rdata[0];
                wb_data[{rsp_cnt, 1'b1}] <= mem_rdata[1];
                rsp_cnt                  <= rsp_cnt + CNT_W'(1);
                if (state == WAIT && rsp_cnt == CNT_W'(3)) begin
                    state      <= DONE;
                    wb_valid   <= 1'b1;
                    wb_warp    <= warp_q;
                    wb_reg     <= dest_q;
                    done_valid <= 1'b1;
                    done_warp  <= warp_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: directed scenarios plus randomized requests checked
// against a word-addressed memory reference model.
module tb_dmem_ctrl;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 8;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   req_valid;
    logic                   req_ready;
    logic [1:0]             req_warp;
    logic [3:0]             req_dest_reg;
    logic                   req_is_store;
    logic [7:0][AW-1:0]     req_addr;
    logic [7:0][DW-1:0]     req_wdata;
    logic                   mem_en;
    logic                   mem_we;
    logic [1:0][AW-1:0]     mem_addr;
    logic [1:0][DW-1:0]     mem_wdata;
    logic                   mem_gnt;
    logic                   mem_rvalid;
    logic [1:0][DW-1:0]     mem_rdata;
    logic                   wb_valid;
    logic [1:0]             wb_warp;
    logic [3:0]             wb_reg;
    logic [7:0][DW-1:0]     wb_data;
    logic                   done_valid;
    logic [1:0]             done_warp;

    always #5 clk = ~clk;

    dmem_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_warp(req_warp),
        .req_dest_reg(req_dest_reg), .req_is_store(req_is_store),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_warp(wb_warp), .wb_reg(wb_reg), .wb_data(wb_data),
        .done_valid(done_valid), .done_warp(done_warp)
    );

    typedef struct {
        logic [1:0]         warp;
        logic [3:0]         dest;
        logic               st;
        logic [7:0][7:0]    addr;
        logic [7:0][15:0]   wd;
    } req_t;
    typedef struct { int cyc; logic we; logic [7:0] a0; logic [7:0] a1; logic [15:0] d0; logic [15:0] d1; } beat_t;
    typedef struct { int cyc; logic [1:0] warp; logic [3:0] rg; logic [127:0] data; } wb_t;
    typedef struct { int cyc; logic [1:0] warp; } done_t;

    int n_chk = 0, n_pass = 0, n_fail = 0;
    int cyc = 0;
    beat_t beat_q[$];
    logic [15:0] stall_q[$];
    wb_t   wb_q[$];
    done_t done_q[$];
    logic [15:0] pend_q[$];
    logic [15:0] pend;
    logic [15:0] mem_bus [256];
    logic [15:0] ref_mem [256];
    logic [7:0][15:0] last_load;
    int beats_this = 0, stall_beat = 0, stall_left = 0;
    int rsp_given = 0, rsp_limit = 99, last_rsp_cyc = 0;
    bit rand_gnt = 0, rand_gap = 0, spur = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bus monitor plus the write side of the memory model.
    initial forever begin
        @(negedge clk);
        if (req_valid && req_ready) beats_this = 0;
        if (mem_en && mem_gnt) begin
            beat_q.push_back('{cyc, mem_we, mem_addr[0], mem_addr[1], mem_wdata[0], mem_wdata[1]});
            beats_this++;
            if (mem_we) begin
                mem_bus[mem_addr[0]] = mem_wdata[0];
                mem_bus[mem_addr[1]] = mem_wdata[1];
            end else begin
                pend_q.push_back({mem_addr[1], mem_addr[0]});
            end
        end else if (mem_en) begin
            stall_q.push_back({mem_addr[0], mem_addr[1]});
        end
        if (wb_valid)   wb_q.push_back('{cyc, wb_warp, wb_reg, wb_data});
        if (done_valid) done_q.push_back('{cyc, done_warp});
    end

    // Memory responder: grant policy and in-order read returns.
    initial forever begin
        @(posedge clk);
        #1;
        if (stall_left > 0 && beats_this == stall_beat) begin
            mem_gnt = 1'b0;
            stall_left--;
        end else begin
            mem_gnt = rand_gnt ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (pend_q.size() > 0 && rsp_given < rsp_limit && (!rand_gap || $urandom_range(0, 2) != 0)) begin
            pend         = pend_q.pop_front();
            mem_rvalid   = 1'b1;
            mem_rdata[0] = mem_bus[pend[7:0]];
            mem_rdata[1] = mem_bus[pend[15:8]];
            rsp_given++;
            last_rsp_cyc = cyc;
        end else if (spur && (req_ready || done_valid)) begin
            mem_rvalid = 1'b1;
            mem_rdata  = {16'($urandom), 16'($urandom)};
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = {16'($urandom), 16'($urandom)};
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic req_t mk(input logic [1:0] w, input logic [3:0] d, input logic s,
                                input logic [7:0] ab, input logic [15:0] db);
        req_t r;
        r.warp = w; r.dest = d; r.st = s;
        for (int i = 0; i < 8; i++) begin
            r.addr[i] = ab + 8'(i);
            r.wd[i]   = db + 16'(i);
        end
        return r;
    endfunction

    function automatic req_t rnd_req();
        req_t r;
        r.warp = 2'($urandom); r.dest = 4'($urandom); r.st = 1'($urandom);
        for (int i = 0; i < 8; i++) begin
            r.addr[i] = 8'h80 + 8'($urandom_range(0, 15));
            r.wd[i]   = 16'($urandom);
        end
        return r;
    endfunction

    task automatic present(input req_t r);
        req_warp = r.warp; req_dest_reg = r.dest; req_is_store = r.st;
        req_addr = r.addr; req_wdata = r.wd; req_valid = 1'b1;
    endtask

    task automatic wait_accept(output int c);
        c = -1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (req_valid && req_ready) begin
                c = cyc;
                break;
            end
        end
        chk("accept_seen", 128'(c >= 0), 1);
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (done_valid) begin
                seen = 1;
                break;
            end
        end
        chk("done_seen", 128'(seen), 1);
        @(negedge clk);
    endtask

    task automatic run_single(input req_t r, output int acc);
        beat_q.delete(); stall_q.delete(); done_q.delete(); wb_q.delete();
        rsp_given = 0;
        @(posedge clk); #1;
        present(r);
        wait_accept(acc);
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_done();
    endtask

    // Compares the logged transaction with what the request implies.
    task automatic check_txn(input req_t r, input int acc, input int exp_rel);
        logic [127:0] o, e;
        logic [7:0][15:0] exp_data;
        int d_exp;
        chk("beat_count", beat_q.size(), 4);
        for (int b = 0; b < 4 && b < beat_q.size(); b++) begin
            o = {beat_q[b].we, beat_q[b].a0, beat_q[b].a1,
                 r.st ? {beat_q[b].d0, beat_q[b].d1} : 32'h0};
            e = {r.st, r.addr[2*b], r.addr[2*b+1], r.st ? {r.wd[2*b], r.wd[2*b+1]} : 32'h0};
            chk($sformatf("beat%0d", b), o, e);
        end
        if (exp_rel >= 0)         d_exp = acc + exp_rel;
        else if (r.st)            d_exp = (beat_q.size() == 4) ? beat_q[3].cyc + 1 : -1;
        else                      d_exp = last_rsp_cyc + 1;
        chk("done_count", done_q.size(), 1);
        if (done_q.size() > 0) begin
            chk("done_cycle", done_q[0].cyc, d_exp);
            chk("done_warp", done_q[0].warp, r.warp);
        end
        if (r.st) begin
            chk("wb_none", wb_q.size(), 0);
            for (int i = 0; i < 8; i++) ref_mem[r.addr[i]] = r.wd[i];
        end else begin
            for (int i = 0; i < 8; i++) exp_data[i] = ref_mem[r.addr[i]];
            chk("wb_count", wb_q.size(), 1);
            if (wb_q.size() > 0) begin
                chk("wb_cycle", wb_q[0].cyc, d_exp);
                chk("wb_dest", {wb_q[0].warp, wb_q[0].rg}, {r.warp, r.dest});
                chk("wb_data", wb_q[0].data, exp_data);
            end
            last_load = exp_data;
        end
        beat_q.delete(); done_q.delete(); wb_q.delete();
    endtask

    initial begin
        req_t r, ra, rb;
        int acc, acc_b;
        for (int i = 0; i < 256; i++) begin
            mem_bus[i] = 16'(i) + 16'h100;
            ref_mem[i] = 16'(i) + 16'h100;
        end
        reset = 1'b0; req_valid = 1'b1; req_warp = '0; req_dest_reg = '0;
        req_is_store = 1'b0; req_addr = '0; req_wdata = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

        // Reset held with a pending request.
        repeat (3) @(negedge clk);
        chk("rst_ready", req_ready, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_done_valid", done_valid, 0);
        req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", req_ready, 1);

        // Directed store, zero-wait grants.
        r = mk(2'd2, 4'd0, 1'b1, 8'h10, 16'h00A0);
        run_single(r, acc);
        chk("ready_cycle6", req_ready, 1);
        check_txn(r, acc, 5);

        // Directed load, 1-cycle memory.
        r = mk(2'd1, 4'd5, 1'b0, 8'h40, 16'h0);
        run_single(r, acc);
        check_txn(r, acc, 6);

        // Load with 3 stall cycles before beat 2.
        stall_beat = 2; stall_left = 3;
        r = mk(2'd3, 4'd9, 1'b0, 8'h10, 16'h0);
        run_single(r, acc);
        chk("stall_len", stall_q.size(), 3);
        for (int k = 0; k < stall_q.size(); k++)
            chk("stall_hold", stall_q[k], {r.addr[4], r.addr[5]});
        check_txn(r, acc, 9);

        // Back-to-back loads with req_valid held and spurious idle responses.
        spur = 1;
        beat_q.delete(); stall_q.delete(); done_q.delete(); wb_q.delete();
        ra = mk(2'd0, 4'd1, 1'b0, 8'h18, 16'h0);
        rb = mk(2'd3, 4'd2, 1'b0, 8'h30, 16'h0);
        @(posedge clk); #1;
        present(ra);
        wait_accept(acc);
        @(posedge clk); #1;
        present(rb);
        wait_accept(acc_b);
        chk("b2b_accept", acc_b, (done_q.size() > 0) ? done_q[0].cyc + 1 : -1);
        check_txn(ra, acc, 6);
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_done();
        check_txn(rb, acc_b, 6);
        repeat (8) @(negedge clk);
        chk("wb_data_hold", wb_data, last_load);
        spur = 0;

        // Reset during WAIT after two responses.
        rsp_limit = 2; rsp_given = 0;
        beat_q.delete(); done_q.delete(); wb_q.delete();
        r = mk(2'd0, 4'd3, 1'b0, 8'h60, 16'h0);
        @(posedge clk); #1;
        present(r);
        wait_accept(acc);
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (beat_q.size() == 4) break;
        end
        chk("rst_setup_beats", beat_q.size(), 4);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        pend_q.delete();
        #1;
        chk("rst_mid_mem_en", mem_en, 0);
        chk("rst_mid_ready", req_ready, 0);
        chk("rst_mid_wb_data", wb_data, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        rsp_limit = 99;
        repeat (3) @(negedge clk);
        chk("rst_no_done", done_q.size(), 0);
        chk("rst_no_wb", wb_q.size(), 0);
        chk("ready_after_rst2", req_ready, 1);
        r = rnd_req();
        r.st = 1'b0;
        run_single(r, acc);
        check_txn(r, acc, 6);

        // Randomized mix with random grants and response gaps.
        rand_gnt = 1; rand_gap = 1;
        for (int t = 0; t < 16; t++) begin
            r = rnd_req();
            run_single(r, acc);
            check_txn(r, acc, -1);
        end
        rand_gnt = 0; rand_gap = 0;

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
